sort_collect3: RTL and testbench
================================

Name: sort_collect3

Overview:
Upstream stage of the three-value sort stage. It accepts a serial stream of WIDTH-bit samples over a valid/ready handshake and packs each run of three into a parallel triple a, b, c. It holds the triple stable, with grp_valid asserted, until the consumer acknowledges it. A flush input closes a partially filled group, padding the missing slots with PAD.

Parameters:
WIDTH, 3, sample width in bits; must match the sort stage width
PAD, 0, value written into unfilled slots on flush
CNT_W, 8, width of the completed-group counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
in_data  input  WIDTH  incoming sample
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a sample this cycle
flush  input  1  close the current partial group
a  output  WIDTH  slot 0, first sample of the group
b  output  WIDTH  slot 1, second sample
c  output  WIDTH  slot 2, third sample
grp_valid  output  1  a/b/c hold a complete or flushed group
grp_ready  input  1  consumer takes the group this cycle
partial  output  1  current group was closed by flush; qualified by grp_valid
grp_cnt  output  CNT_W  number of groups handed off, modulo 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous): state=EMPTY; a=b=c=0; grp_valid=0; partial=0; grp_cnt=0.
- States:
  - EMPTY: no samples held.
  - HAS1: a filled.
  - HAS2: a and b filled.
  - FULL: group presented.
- Accept: a sample is accepted when in_valid && in_ready. The slot written is a, b or c for EMPTY, HAS1 or HAS2 respectively.
- Transitions: EMPTY→HAS1, HAS1→HAS2, HAS2→FULL on each accept.
- Latency: when the third sample is accepted at edge N, grp_valid=1 from edge N until handoff.
- in_ready = (state != FULL) || grp_ready. Back-to-back streaming therefore has no bubble.
- Handoff: occurs when grp_valid && grp_ready; grp_cnt increments at that edge and wraps from max to 0.
  - Handoff with no accept: FULL→EMPTY.
  - Handoff with a simultaneous accept: the new sample goes into a, state→HAS1, grp_valid falls.
- Output stability: in FULL without grp_ready, a, b, c and partial must not change.
- Unfilled slots: outside FULL, unfilled slots hold their previous values and are don't-care until grp_valid.
- Flush in HAS1 or HAS2 (no accept that cycle): remaining slots are written with PAD, state→FULL, partial=1.
- Flush together with an accept:
  - The accepted sample is stored first, then the remaining slots are padded.
  - If that accept completes slot c, it is a normal full group with partial=0.
  - Flush+accept in EMPTY produces a = in_data, b = c = PAD, partial=1.
- Flush ignored: flush in EMPTY (without an accept) or in FULL has no effect.
- partial clears to 0 when a new group starts, i.e. at the first accept after handoff.
- Reset mid-group discards any partial contents. An unacknowledged group is lost, and grp_cnt is not incremented for it.
- Width rules: samples are stored unmodified. PAD is truncated to WIDTH bits.

Decomposition:
- Package sort_pkg holds:
  - WIDTH default, shared with the sort stage.
  - 2-bit state encoding: EMPTY=0, HAS1=1, HAS2=2, FULL=3.
  - PAD default.
- Single module; no sub-module. The state register and slot-write decode fit in one always block plus the output logic.

Test Plan:
1. Reset, then stream 5, 2, 7 with in_valid=1 and grp_ready=0 → after the third edge: a=5, b=2, c=7, grp_valid=1, partial=0, in_ready=0. Outputs stay stable for 4 cycles while grp_ready=0.
2. Continuous stream 1..6 with grp_ready=1 → groups (1,2,3) then (4,5,6) with no bubble; in_ready stays 1; grp_cnt=2.
3. Accept 6, then flush the next cycle with in_valid=0 → a=6, b=0, c=0, partial=1, grp_valid=1. After handoff, stream 3, 3, 3 → partial=0.
4. HAS2 holding (4,1), then flush and accept of 2 in the same cycle → (4,1,2) with partial=0. Separately, flush while EMPTY → no change.
5. Assert rst=0 asynchronously mid-cycle while in HAS2 → all outputs go to 0 immediately with no clock edge. After release, the next three samples form a fresh group starting at slot a.
6. Hand off 256 groups → grp_cnt wraps to 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the three-value sort path: sample width, pad value
// and the collector state encoding.
package sort_pkg;

  localparam int SORT_WIDTH = 3;
  localparam int SORT_PAD   = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HAS1  = 2'd1,
    ST_HAS2  = 2'd2,
    ST_FULL  = 2'd3
  } collect_state_e;

endpackage

// File: rtl/sort_collect3.sv
// Packs a serial valid/ready sample stream into parallel triples (a, b, c)
// for the sort stage. A flush closes a partial group, padding with PAD.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no samples held
// ST_HAS1  | slot a filled
// ST_HAS2  | slots a and b filled
// ST_FULL  | group presented on a/b/c, grp_valid high
module sort_collect3
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH,
  parameter int PAD   = SORT_PAD,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             grp_valid,
  input  logic             grp_ready,
  output logic             partial,
  output logic [CNT_W-1:0] grp_cnt
);

  localparam logic [WIDTH-1:0] PAD_W = WIDTH'(PAD);

  collect_state_e   state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             partial_q, partial_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             handoff;

  assign grp_valid = (state_q == ST_FULL);
  assign in_ready  = (state_q != ST_FULL) || grp_ready;
  assign accept    = in_valid && in_ready;
  assign handoff   = grp_valid && grp_ready;

  // Next-state, slot-write decode and hand-off counter
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          a_d       = in_data;
          partial_d = 1'b0;
          state_d   = ST_HAS1;
          if (flush) begin
            b_d       = PAD_W;
            c_d       = PAD_W;
            partial_d = 1'b1;
            state_d   = ST_FULL;
          end
        end
      end
      ST_HAS1: begin
        if (accept) begin
          b_d     = in_data;
          state_d = ST_HAS2;
          if (flush) begin
            c_d       = PAD_W;
            partial_d = 1'b1;
            state_d   = ST_FULL;
          end
        end else if (flush) begin
          b_d       = PAD_W;
          c_d       = PAD_W;
          partial_d = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_HAS2: begin
        if (accept) begin
          // Completing slot c is a full group even if flush is also raised
          c_d       = in_data;
          partial_d = 1'b0;
          state_d   = ST_FULL;
        end else if (flush) begin
          c_d       = PAD_W;
          partial_d = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (handoff) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (accept) begin
            a_d       = in_data;
            partial_d = 1'b0;
            state_d   = ST_HAS1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State, slot and counter registers; reset drops any held group
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      partial_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign partial = partial_q;
  assign grp_cnt = cnt_q;

endmodule

// File: tb/tb_sort_collect3.sv
// Directed bench for sort_collect3 with hand-computed expectations.
module tb_sort_collect3;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] a, b, c;
  logic             grp_valid;
  logic             grp_ready = 1'b0;
  logic             partial;
  logic [CNT_W-1:0] grp_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  sort_collect3 #(.WIDTH(WIDTH), .PAD(0), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .c         (c),
    .grp_valid (grp_valid),
    .grp_ready (grp_ready),
    .partial   (partial),
    .grp_cnt   (grp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grp(input string tag, input int ea, input int eb, input int ec,
                         input logic egv, input logic epart);
    chk({tag, ".a"}, 32'(a), 32'(ea));
    chk({tag, ".b"}, 32'(b), 32'(eb));
    chk({tag, ".c"}, 32'(c), 32'(ec));
    chk({tag, ".grp_valid"}, 32'(grp_valid), 32'(egv));
    chk({tag, ".partial"}, 32'(partial), 32'(epart));
  endtask

  task automatic push(input int v);
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    step();
  endtask

  initial begin
    int t1 [3] = '{5, 2, 7};

    // 1: reset state, then a held group
    #12;
    chk_grp("rst", 0, 0, 0, 1'b0, 1'b0);
    chk("rst.cnt", 32'(grp_cnt), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    rst = 1'b1;
    #1;
    foreach (t1[i]) push(t1[i]);
    chk_grp("t1", 5, 2, 7, 1'b1, 1'b0);
    chk("t1.in_ready", 32'(in_ready), 0);
    in_data = 3'd0;
    flush   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_grp("t1.hold", 5, 2, 7, 1'b1, 1'b0);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    grp_ready = 1'b1;
    step();
    chk("t1.ho.gv", 32'(grp_valid), 0);
    chk("t1.ho.cnt", 32'(grp_cnt), 1);

    // 2: continuous stream 1..6 with no bubble
    for (int v = 1; v <= 6; v++) begin
      #0 chk("t2.in_ready", 32'(in_ready), 1);
      push(v);
      if (v == 3) chk_grp("t2.g1", 1, 2, 3, 1'b1, 1'b0);
      if (v == 4) begin
        chk("t2.g1gone", 32'(grp_valid), 0);
        chk("t2.a4", 32'(a), 4);
        chk("t2.cnt1", 32'(grp_cnt), 2);
      end
    end
    chk_grp("t2.g2", 4, 5, 6, 1'b1, 1'b0);
    chk("t2.in_ready_full", 32'(in_ready), 1);
    in_valid = 1'b0;
    step();
    chk("t2.cnt2", 32'(grp_cnt), 3);

    // 3: flush after one sample, then a fresh full group
    grp_ready = 1'b0;
    push(6);
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    chk_grp("t3.flush", 6, 0, 0, 1'b1, 1'b1);
    grp_ready = 1'b1;
    step();
    chk("t3.cnt", 32'(grp_cnt), 4);
    grp_ready = 1'b0;
    push(3);
    chk("t3.partclr", 32'(partial), 0);
    push(3);
    push(3);
    in_valid = 1'b0;
    chk_grp("t3.g", 3, 3, 3, 1'b1, 1'b0);
    grp_ready = 1'b1;
    step();
    grp_ready = 1'b0;

    // 4: flush with completing accept; flush ignored in EMPTY and FULL
    push(4);
    push(1);
    flush = 1'b1;
    push(2);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_grp("t4.full", 4, 1, 2, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_grp("t4.flfull", 4, 1, 2, 1'b1, 1'b0);
    grp_ready = 1'b1;
    step();
    grp_ready = 1'b0;
    chk("t4.cnt", 32'(grp_cnt), 6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_grp("t4.flempty", 4, 1, 2, 1'b0, 1'b0);
    push(7);
    push(0);
    push(5);
    in_valid = 1'b0;
    chk_grp("t4.after", 7, 0, 5, 1'b1, 1'b0);
    grp_ready = 1'b1;
    step();
    grp_ready = 1'b0;
    chk("t4.cnt2", 32'(grp_cnt), 7);

    // 5: asynchronous reset while in HAS2
    push(6);
    push(5);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_grp("t5.rst", 0, 0, 0, 1'b0, 1'b0);
    chk("t5.cnt", 32'(grp_cnt), 0);
    #2 rst = 1'b1;
    push(1);
    push(2);
    push(3);
    in_valid = 1'b0;
    chk_grp("t5.fresh", 1, 2, 3, 1'b1, 1'b0);
    grp_ready = 1'b1;
    step();
    chk("t5.cnt1", 32'(grp_cnt), 1);

    // 6: 255 more hand-offs wrap the counter
    for (int g = 0; g < 255; g++) begin
      push(1);
      push(2);
      push(3);
    end
    chk("t6.cnt255", 32'(grp_cnt), 255);
    in_valid = 1'b0;
    step();
    chk("t6.wrap", 32'(grp_cnt), 0);
    chk("t6.gv", 32'(grp_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
